// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared definitions for the FFT result drain path: the
//               unloader FSM state type, the default index width and a
//               bit-reversal helper used for natural-order readout.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int NUMSAMPLES_DEF = 32;
    localparam int IDXW           = $clog2(NUMSAMPLES_DEF);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RELEASE = 3'd3,
        ST_STREAM  = 3'd4
    } unl_state_t;

    // Reverse the low 'width' bits of idx; bits at and above 'width' are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[5'(i)] = idx[5'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : fft_out_buf
// Description : Frame buffer of NUMSAMPLES x WORDSIZE words. One write port
//               stores four bank words at once (entries 4a..4a+3), one read
//               port returns a single word through an output register.
// Ports       : clk, rst_n      - clock, async active-low reset (read reg only)
//               wr_en, wr_addr  - write strobe and bank address a
//               wr_data[b]      - word stored at entry 4a+b
//               rd_en, rd_addr  - load the read register from entry rd_addr
//               rd_data         - registered read data, 0 after reset
// Revision    : 1.0 - initial release
// ============================================================================
module fft_out_buf #(
    parameter int WORDSIZE   = 16,
    parameter int NUMSAMPLES = 32,
    parameter int ADDRSIZE   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDRSIZE-1:0]      wr_addr,
    input  logic [3:0][WORDSIZE-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [ADDRSIZE+1:0]      rd_addr,
    output logic [WORDSIZE-1:0]      rd_data
);

    logic [WORDSIZE-1:0] r_mem [NUMSAMPLES];
    logic [WORDSIZE-1:0] r_rd_data;

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[{wr_addr, 2'd0}] <= wr_data[0];
            r_mem[{wr_addr, 2'd1}] <= wr_data[1];
            r_mem[{wr_addr, 2'd2}] <= wr_data[2];
            r_mem[{wr_addr, 2'd3}] <= wr_data[3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fft_unloader.sv
`default_nettype none
// ============================================================================
// Module      : fft_unloader
// Description : Drains a finished FFT frame. On fft_done it requests the
//               result banks (output_data), captures four words per cycle
//               into a local frame buffer, releases the core and streams the
//               frame out on a valid/ready interface tagged with its index.
// Config      : FFT_UNLOADER_BITREV_EN - when defined, word k is read from
//               entry bitrev(k) so the stream is in natural frequency order;
//               otherwise raw bank order is streamed.
// Ports       : clk, rst_n               - clock, async active-low reset
//               fft_done                 - core done level
//               output_data              - bank readout request to the core
//               data_in0..3              - bank words from the core
//               dout, dout_idx, dout_last, dout_valid / dout_ready - stream
//               busy                     - FSM not idle
//               frame_done               - pulse after the last handshake
// Revision    : 1.0 - initial release
// ============================================================================
module fft_unloader
    import fft_pkg::*;
#(
    parameter int WORDSIZE   = 16,
    parameter int NUMSAMPLES = 32,
    parameter int ADDRSIZE   = 3,
    parameter int RD_LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fft_done,
    output logic                          output_data,
    input  logic [WORDSIZE-1:0]           data_in0,
    input  logic [WORDSIZE-1:0]           data_in1,
    input  logic [WORDSIZE-1:0]           data_in2,
    input  logic [WORDSIZE-1:0]           data_in3,
    output logic [WORDSIZE-1:0]           dout,
    output logic [$clog2(NUMSAMPLES)-1:0] dout_idx,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          dout_last,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int c_idx_w  = $clog2(NUMSAMPLES);
    localparam int c_nbeats = NUMSAMPLES / 4;
    localparam int c_cnt_w  = $clog2(RD_LATENCY + c_nbeats) + 1;

    localparam logic [c_cnt_w-1:0] c_req_last = c_cnt_w'(RD_LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_cap_last = c_cnt_w'(c_nbeats - 1);
    localparam logic [c_idx_w-1:0] c_k_last   = c_idx_w'(NUMSAMPLES - 1);

    unl_state_t           r_state;
    unl_state_t           w_next_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_armed;
    logic                 r_output_data;
    logic [c_idx_w-1:0]   r_k;
    logic                 r_last;
    logic                 r_frame_done;

    logic                 w_hs;
    logic                 w_final_hs;
    logic                 w_rd_en;
    logic [c_idx_w-1:0]   w_rd_k;
    logic [c_idx_w-1:0]   w_rd_addr;
    logic [WORDSIZE-1:0]  w_rd_data;

    // Valid is simply "in STREAM", so it can never drop before a handshake.
    assign w_hs       = (r_state == ST_STREAM) && dout_ready;
    assign w_final_hs = w_hs && (r_k == c_k_last);

    // ------------------------------------------------------------------
    // Next-state and read-port control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        w_rd_k       = '0;

        unique case (r_state)
            ST_IDLE:    if (fft_done && r_armed)  w_next_state = ST_REQ;
            ST_REQ:     if (r_cnt == c_req_last)  w_next_state = ST_CAPTURE;
            ST_CAPTURE: if (r_cnt == c_cap_last)  w_next_state = ST_RELEASE;
            ST_RELEASE:                           w_next_state = ST_STREAM;
            ST_STREAM:  if (w_final_hs)           w_next_state = ST_IDLE;
            default:                              w_next_state = ST_IDLE;
        endcase

        // Prefetch word 0 while leaving RELEASE, then word k+1 on each
        // handshake; no fetch after the final word so the index never wraps.
        if (r_state == ST_RELEASE) begin
            w_rd_en = 1'b1;
            w_rd_k  = '0;
        end else if (w_hs && (r_k != c_k_last)) begin
            w_rd_en = 1'b1;
            w_rd_k  = r_k + 1'b1;
        end
    end

`ifdef FFT_UNLOADER_BITREV_EN
    assign w_rd_addr = c_idx_w'(bitrev(32'(w_rd_k), c_idx_w));
`else
    assign w_rd_addr = w_rd_k;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Counters, arming and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_armed       <= 1'b1;
            r_output_data <= 1'b0;
            r_k           <= '0;
            r_last        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            // Arming needs done to be seen low, so a level-held done can
            // launch only one frame.
            if ((r_state == ST_IDLE) && (w_next_state == ST_REQ)) begin
                r_armed <= 1'b0;
            end else if (!fft_done) begin
                r_armed <= 1'b1;
            end

            // Driven from next state so the request is a clean register
            // covering exactly the REQ and CAPTURE cycles.
            r_output_data <= (w_next_state == ST_REQ) || (w_next_state == ST_CAPTURE);

            // Shared counter: latency wait in REQ, bank address in CAPTURE.
            if (r_state != w_next_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_REQ) || (r_state == ST_CAPTURE)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_rd_en) begin
                r_k    <= w_rd_k;
                r_last <= (w_rd_k == c_k_last);
            end

            r_frame_done <= w_final_hs;
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------
    fft_out_buf #(
        .WORDSIZE   (WORDSIZE),
        .NUMSAMPLES (NUMSAMPLES),
        .ADDRSIZE   (ADDRSIZE)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (r_state == ST_CAPTURE),
        .wr_addr (r_cnt[ADDRSIZE-1:0]),
        .wr_data ({data_in3, data_in2, data_in1, data_in0}),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    assign output_data = r_output_data;
    assign dout        = w_rd_data;
    assign dout_idx    = r_k;
    assign dout_last   = r_last;
    assign dout_valid  = (r_state == ST_STREAM);
    assign busy        = (r_state != ST_IDLE);
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_unloader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fft_unloader
// Description : Self-checking bench for fft_unloader. A bank model emulates
//               the core's readout latency; a frame-level reference (queue of
//               expected words) checks the stream, plus corner sequences for
//               level-held done and reset during streaming.
//               Define FFT_UNLOADER_BITREV_EN for both bench and RTL to test
//               the natural-order build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_unloader;

    localparam int WORDSIZE   = 16;
    localparam int NUMSAMPLES = 32;
    localparam int ADDRSIZE   = 3;
    localparam int RD_LATENCY = 3;
    localparam int NBEATS     = NUMSAMPLES / 4;
    localparam int IDX_BITS   = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                fft_done = 1'b0;
    logic                output_data;
    logic [15:0]         data_in0 = '0, data_in1 = '0, data_in2 = '0, data_in3 = '0;
    logic [15:0]         dout;
    logic [4:0]          dout_idx;
    logic                dout_valid;
    logic                dout_ready = 1'b0;
    logic                dout_last;
    logic                busy;
    logic                frame_done;

    fft_unloader #(
        .WORDSIZE   (WORDSIZE),
        .NUMSAMPLES (NUMSAMPLES),
        .ADDRSIZE   (ADDRSIZE),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fft_done    (fft_done),
        .output_data (output_data),
        .data_in0    (data_in0),
        .data_in1    (data_in1),
        .data_in2    (data_in2),
        .data_in3    (data_in3),
        .dout        (dout),
        .dout_idx    (dout_idx),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [4:0]  i;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] bank [NUMSAMPLES];
    logic [15:0] rx   [NUMSAMPLES];
    int          rx_cnt = 0;
    int          fd_cnt = 0;
    int          od_pulses = 0;
    int          od_len_last = 0;
    int          ready_pct = 100;
    logic        od_bank = 1'b0;
    logic        rel_state_ok = 1'b0;
    logic        valid_after_rel = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic int rev_idx(input int k);
        int r;
        r = 0;
        for (int i = 0; i < IDX_BITS; i++) begin
            if (((k >> i) & 1) != 0) r = r | (1 << (IDX_BITS - 1 - i));
        end
        return r;
    endfunction

    // Fill the core's banks and queue the words the stream must deliver.
    task automatic load_frame(input int pattern);
        int src;
        exp_t e;
        for (int j = 0; j < NUMSAMPLES; j++) begin
            if (pattern == 0) bank[j] = 16'(16 * (j / 4) + (j % 4));
            else              bank[j] = 16'($urandom);
        end
        exp_q.delete();
        for (int k = 0; k < NUMSAMPLES; k++) begin
`ifdef FFT_UNLOADER_BITREV_EN
            src = rev_idx(k);
`else
            src = k;
`endif
            e.d = bank[src];
            e.i = 5'(k);
            e.l = (k == NUMSAMPLES - 1);
            exp_q.push_back(e);
        end
        rx_cnt = 0;
    endtask

    // ------------------------------------------------------------------
    // Core bank model: after output_data has been sampled high n times,
    // address n-RD_LATENCY is presented; anything else is noise.
    // ------------------------------------------------------------------
    initial begin
        int n;
        int a;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (od_bank) n++;
            else         n = 0;
            a = n - RD_LATENCY;
            if (a >= 0 && a < NBEATS) begin
                data_in0 = bank[4*a];
                data_in1 = bank[4*a+1];
                data_in2 = bank[4*a+2];
                data_in3 = bank[4*a+3];
            end else begin
                data_in0 = 16'($urandom);
                data_in1 = 16'($urandom);
                data_in2 = 16'($urandom);
                data_in3 = 16'($urandom);
            end
        end
    end

    // Consumer ready pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dout_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // ------------------------------------------------------------------
    // Stream monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    initial begin
        logic        od_prev;
        logic        stall;
        logic        rel_pending;
        int          od_run;
        logic [15:0] s_dout;
        logic [4:0]  s_idx;
        logic        s_last;
        exp_t        e;
        od_prev = 1'b0; stall = 1'b0; rel_pending = 1'b0; od_run = 0;
        s_dout = '0; s_idx = '0; s_last = 1'b0;
        forever begin
            @(negedge clk);
            od_bank = output_data;
            if (!rst_n) begin
                od_prev = 1'b0; stall = 1'b0; rel_pending = 1'b0; od_run = 0;
            end else begin
                if (rel_pending) begin
                    valid_after_rel = dout_valid;
                    rel_pending = 1'b0;
                end
                if (output_data) begin
                    od_run++;
                end else if (od_prev) begin
                    od_len_last  = od_run;
                    od_run       = 0;
                    od_pulses++;
                    rel_state_ok = busy && !dout_valid;
                    rel_pending  = 1'b1;
                end
                if (dout_valid) begin
                    if (stall) begin
                        chk("stall_dout", dout, s_dout);
                        chk("stall_idx", dout_idx, s_idx);
                        chk("stall_last", dout_last, s_last);
                    end
                    if (dout_ready) begin
                        stall = 1'b0;
                        rx_cnt++;
                        rx[dout_idx] = dout;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL extra_word: got idx %0d, required no word", dout_idx);
                        end else begin
                            e = exp_q.pop_front();
                            chk("word_data", dout, e.d);
                            chk("word_idx", dout_idx, e.i);
                            chk("word_last", dout_last, e.l);
                        end
                    end else begin
                        stall  = 1'b1;
                        s_dout = dout;
                        s_idx  = dout_idx;
                        s_last = dout_last;
                    end
                end else begin
                    if (stall) chk("valid_retracted", dout_valid, 1);
                    stall = 1'b0;
                end
                if (frame_done) begin
                    fd_cnt++;
                    chk("fd_valid_low", dout_valid, 0);
                    chk("fd_queue_empty", exp_q.size(), 0);
                end
                od_prev = output_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame helpers
    // ------------------------------------------------------------------
    typedef struct {
        int pattern;      // 0: 16a+b, 1: random words
        int ready_pct;    // consumer ready probability
        int hold;         // keep fft_done high after the trigger
        int exp_words;
        int exp_od_len;
    } frame_vec_t;

    typedef struct {
        int          k;
        logic [15:0] exp_dout;
    } spot_t;

    task automatic wait_fd(input int fd0);
        int n;
        n = 0;
        while (fd_cnt == fd0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("frame_done_count", fd_cnt - fd0, 1);
    endtask

    task automatic run_frame(input frame_vec_t v);
        int fd0;
        fd0 = fd_cnt;
        load_frame(v.pattern);
        ready_pct = v.ready_pct;
        @(posedge clk); #1 fft_done = 1'b1;
        @(posedge clk); #1 if (v.hold == 0) fft_done = 1'b0;
        wait_fd(fd0);
        @(posedge clk);
        chk("rx_count", rx_cnt, v.exp_words);
        chk("od_high_len", od_len_last, v.exp_od_len);
        chk("release_cycle", rel_state_ok, 1);
        chk("valid_after_release", valid_after_rel, 1);
        chk("first_word", rx[0], bank[0]);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        frame_vec_t fv[5];
        spot_t      sp[5];
        int         fd0;
        int         od0;
        int         busy_seen;
        int         n;
        logic       found;

        fv[0] = '{0, 100, 0, NUMSAMPLES, RD_LATENCY + NBEATS};
        fv[1] = '{1, 100, 0, NUMSAMPLES, RD_LATENCY + NBEATS};
        fv[2] = '{1,  50, 0, NUMSAMPLES, RD_LATENCY + NBEATS};
        fv[3] = '{1,  20, 0, NUMSAMPLES, RD_LATENCY + NBEATS};
        fv[4] = '{0,  70, 1, NUMSAMPLES, RD_LATENCY + NBEATS};

`ifdef FFT_UNLOADER_BITREV_EN
        sp[0] = '{0,  16'h0000};
        sp[1] = '{1,  16'h0040};
        sp[2] = '{2,  16'h0020};
        sp[3] = '{5,  16'h0050};
        sp[4] = '{31, 16'h0073};
`else
        sp[0] = '{0,  16'h0000};
        sp[1] = '{1,  16'h0001};
        sp[2] = '{2,  16'h0002};
        sp[3] = '{5,  16'h0011};
        sp[4] = '{31, 16'h0073};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_output_data", output_data, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_idx", dout_idx, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int f = 0; f < 5; f++) begin
            run_frame(fv[f]);
            if (f == 0) begin
                for (int s = 0; s < 5; s++) chk("spot_word", rx[sp[s].k], sp[s].exp_dout);
            end
        end

        // fft_done still held high from the last frame: no new request.
        od0 = od_pulses;
        busy_seen = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (busy) busy_seen++;
        end
        chk("held_done_no_busy", busy_seen, 0);
        chk("held_done_no_req", od_pulses, od0);

        // Low then high again re-arms and starts exactly one frame.
        load_frame(1);
        ready_pct = 100;
        fd0 = fd_cnt;
        @(posedge clk); #1 fft_done = 1'b0;
        @(posedge clk); #1 fft_done = 1'b1;
        @(posedge clk); #1 fft_done = 1'b0;
        wait_fd(fd0);
        @(posedge clk);
        chk("rearm_rx_count", rx_cnt, NUMSAMPLES);

        // Reset while streaming word 10.
        load_frame(1);
        ready_pct = 100;
        fd0 = fd_cnt;
        @(posedge clk); #1 fft_done = 1'b1;
        @(posedge clk); #1 fft_done = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 300) begin
            @(posedge clk); #2;
            if (dout_valid && dout_idx == 5'd10) found = 1'b1;
            n++;
        end
        chk("reached_k10", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_output_data", output_data, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_dout_idx", dout_idx, 0);
        chk("midrst_dout_valid", dout_valid, 0);
        chk("midrst_dout_last", dout_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_done", frame_done, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        chk("midrst_no_frame_done", fd_cnt, fd0);

        run_frame(fv[0]);
        for (int s = 0; s < 5; s++) chk("post_reset_spot", rx[sp[s].k], sp[s].exp_dout);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
